// File: rtl/rv32_pipeline_controller.sv
// rv32_pipeline_controller: central stall/flush/halt sequencer for the 5-stage rv32 core.
//   in : clk, resetn (sync, active-low), decode_stall, exec_branch_taken,
//        exec_branch_target[31:0], dmem_ready, halt_req (level), resume_req (pulse)
//   out: fetch/decode/exec/mem_stop, decode_set_nop, decode_set_nop_pc[31:0],
//        fetch_redirect, fetch_redirect_pc[31:0], halted,
//        perf_stall_cnt[31:0], perf_flush_cnt[31:0]
// Optional perf counters: define RV32_PIPE_PERF_CNT_EN (otherwise both read 0).
module rv32_pipeline_controller #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        decode_stall,
  input  logic        exec_branch_taken,
  input  logic [31:0] exec_branch_target,
  input  logic        dmem_ready,
  input  logic        halt_req,
  input  logic        resume_req,
  output logic        fetch_stop,
  output logic        decode_stop,
  output logic        exec_stop,
  output logic        mem_stop,
  output logic        decode_set_nop,
  output logic [31:0] decode_set_nop_pc,
  output logic        fetch_redirect,
  output logic [31:0] fetch_redirect_pc,
  output logic        halted,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic [1:0] {RUN, FLUSH, HALTING, HALTED} state_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic [31:0] saved_pc_q, saved_pc_d;

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    pending_d         = pending_q;
    saved_pc_d        = saved_pc_q;
    fetch_stop        = 1'b0;
    decode_stop       = 1'b0;
    exec_stop         = 1'b0;
    mem_stop          = 1'b0;
    decode_set_nop    = 1'b0;
    decode_set_nop_pc = '0;
    fetch_redirect    = 1'b0;
    fetch_redirect_pc = '0;
    halted            = 1'b0;

    if (state_q != HALTED && !dmem_ready) begin
      // Global freeze: exec re-presents any event next cycle.
      fetch_stop  = 1'b1;
      decode_stop = 1'b1;
      exec_stop   = 1'b1;
      mem_stop    = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (pending_q) begin
            fetch_redirect    = 1'b1;
            fetch_redirect_pc = saved_pc_q;
            pending_d         = 1'b0;
          end
          if (exec_branch_taken) begin
            fetch_redirect    = 1'b1;
            fetch_redirect_pc = exec_branch_target;
            decode_set_nop    = 1'b1;
            decode_set_nop_pc = exec_branch_target;
            saved_pc_d        = exec_branch_target;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_INIT;
            end
          end else if (halt_req) begin
            state_d = HALTING;
            cnt_d   = DRAIN_INIT;
          end else if (decode_stall) begin
            // Decode inserts its own bubble, so only fetch is held.
            fetch_stop = 1'b1;
          end
        end
        FLUSH: begin
          decode_set_nop    = 1'b1;
          decode_set_nop_pc = saved_pc_q;
          if (cnt_q <= 4'd1) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        HALTING: begin
          fetch_stop        = 1'b1;
          decode_set_nop    = 1'b1;
          decode_set_nop_pc = saved_pc_q;
          // A branch resolved while draining is replayed as a redirect on resume.
          if (exec_branch_taken) begin
            saved_pc_d = exec_branch_target;
            pending_d  = 1'b1;
          end
          if (cnt_q <= 4'd1) begin
            state_d = HALTED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        HALTED: begin
          fetch_stop  = 1'b1;
          decode_stop = 1'b1;
          exec_stop   = 1'b1;
          mem_stop    = 1'b1;
          halted      = 1'b1;
          if (resume_req) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      saved_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      saved_pc_q <= saved_pc_d;
    end
  end

`ifdef RV32_PIPE_PERF_CNT_EN
  logic        stall_evt, flush_evt;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  assign stall_evt = (state_q != HALTED && !dmem_ready) ||
                     (state_q == RUN && dmem_ready && !exec_branch_taken &&
                      !halt_req && decode_stall);
  assign flush_evt = (state_q == RUN) && dmem_ready && exec_branch_taken;

  assign perf_stall_d = stall_evt ? perf_stall_q + 32'd1 : perf_stall_q;
  assign perf_flush_d = flush_evt ? perf_flush_q + 32'd1 : perf_flush_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_rv32_pipeline_controller.sv
module tb_rv32_pipeline_controller;

  logic        clk = 1'b0;
  logic        resetn;
  logic        decode_stall;
  logic        exec_branch_taken;
  logic [31:0] exec_branch_target;
  logic        dmem_ready;
  logic        halt_req;
  logic        resume_req;
  logic        fetch_stop;
  logic        decode_stop;
  logic        exec_stop;
  logic        mem_stop;
  logic        decode_set_nop;
  logic [31:0] decode_set_nop_pc;
  logic        fetch_redirect;
  logic [31:0] fetch_redirect_pc;
  logic        halted;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  rv32_pipeline_controller #(
    .FLUSH_CYCLES(2),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .decode_stall      (decode_stall),
    .exec_branch_taken (exec_branch_taken),
    .exec_branch_target(exec_branch_target),
    .dmem_ready        (dmem_ready),
    .halt_req          (halt_req),
    .resume_req        (resume_req),
    .fetch_stop        (fetch_stop),
    .decode_stop       (decode_stop),
    .exec_stop         (exec_stop),
    .mem_stop          (mem_stop),
    .decode_set_nop    (decode_set_nop),
    .decode_set_nop_pc (decode_set_nop_pc),
    .fetch_redirect    (fetch_redirect),
    .fetch_redirect_pc (fetch_redirect_pc),
    .halted            (halted),
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_flush_cnt    (perf_flush_cnt)
  );

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        hl;
    logic        rs;
    logic [3:0]  stops;   // {fetch, decode, exec, mem}
    logic        nop;
    logic [31:0] npc;
    logic        rd;
    logic [31:0] rpc;
    logic        hlt;
  } vec_t;

  localparam logic [3:0] S0 = 4'b0000;
  localparam logic [3:0] SF = 4'b1000;
  localparam logic [3:0] SA = 4'b1111;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic br, input logic [31:0] tgt,
                              input logic rdy, input logic hl, input logic rs,
                              input logic [3:0] stops, input logic nop, input logic [31:0] npc,
                              input logic rd, input logic [31:0] rpc, input logic hlt);
    vec_t v;
    v.st = st; v.br = br; v.tgt = tgt; v.rdy = rdy; v.hl = hl; v.rs = rs;
    v.stops = stops; v.nop = nop; v.npc = npc; v.rd = rd; v.rpc = rpc; v.hlt = hlt;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 32'h0, 1, 0, 0, S0, 0, 32'h0, 0, 32'h0, 0);
  endfunction

  task automatic drive(input vec_t v);
    decode_stall       = v.st;
    exec_branch_taken  = v.br;
    exec_branch_target = v.tgt;
    dmem_ready         = v.rdy;
    halt_req           = v.hl;
    resume_req         = v.rs;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge.
  task automatic apply(input vec_t v, input string name);
    logic [3:0] got_stops;
    drive(v);
    #1;
    got_stops = {fetch_stop, decode_stop, exec_stop, mem_stop};
    n_checks++;
    if (got_stops !== v.stops || decode_set_nop !== v.nop || decode_set_nop_pc !== v.npc ||
        fetch_redirect !== v.rd || fetch_redirect_pc !== v.rpc || halted !== v.hlt) begin
      n_fail++;
      $display("FAIL %s: got stops=%b nop=%b nop_pc=%h redir=%b redir_pc=%h halted=%b, expected stops=%b nop=%b nop_pc=%h redir=%b redir_pc=%h halted=%b",
               name, got_stops, decode_set_nop, decode_set_nop_pc, fetch_redirect,
               fetch_redirect_pc, halted, v.stops, v.nop, v.npc, v.rd, v.rpc, v.hlt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial begin
    // Table: one entry per clock, starting right after reset.
    tbl.push_back(idle());                                                    // 0 reset state
    tbl.push_back(idle());                                                    // 1
    tbl.push_back(mk(1, 1, 32'h100, 1, 0, 0, S0, 1, 32'h100, 1, 32'h100, 0)); // 2 branch beats stall
    tbl.push_back(mk(0, 1, 32'h300, 1, 0, 0, S0, 1, 32'h100, 0, 32'h0, 0));   // 3 flush, wrong-path ignored
    tbl.push_back(idle());                                                    // 4
    tbl.push_back(mk(1, 0, 32'h0, 1, 0, 0, SF, 0, 32'h0, 0, 32'h0, 0));       // 5 stall
    tbl.push_back(mk(1, 0, 32'h0, 0, 0, 0, SA, 0, 32'h0, 0, 32'h0, 0));       // 6 stall + freeze
    tbl.push_back(mk(1, 0, 32'h0, 1, 0, 0, SF, 0, 32'h0, 0, 32'h0, 0));       // 7 stall
    tbl.push_back(idle());                                                    // 8
    tbl.push_back(mk(0, 1, 32'h400, 0, 0, 0, SA, 0, 32'h0, 0, 32'h0, 0));     // 9 frozen branch
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, S0, 0, 32'h0, 0, 32'h0, 0));       // 10 halt accepted
    tbl.push_back(mk(0, 1, 32'h200, 1, 1, 0, SF, 1, 32'h100, 0, 32'h0, 0));   // 11 draining, branch saved
    tbl.push_back(mk(0, 0, 32'h0, 0, 1, 0, SA, 0, 32'h0, 0, 32'h0, 0));       // 12 freeze in drain
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, SF, 1, 32'h200, 0, 32'h0, 0));     // 13
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, SF, 1, 32'h200, 0, 32'h0, 0));     // 14
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 0, SA, 0, 32'h0, 0, 32'h0, 1));       // 15 halted
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, SA, 0, 32'h0, 0, 32'h0, 1));       // 16 halted ignores freeze
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 1, SA, 0, 32'h0, 0, 32'h0, 1));       // 17 resume
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 0, S0, 0, 32'h0, 1, 32'h200, 0));     // 18 pending redirect
    tbl.push_back(idle());                                                    // 19 flag cleared
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, S0, 0, 32'h0, 0, 32'h0, 0));       // 20 halt
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, SF, 1, 32'h200, 0, 32'h0, 0));   // 21-23
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 1, SA, 0, 32'h0, 0, 32'h0, 1));       // 24 resume, halt still high
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, S0, 0, 32'h0, 0, 32'h0, 0));       // 25 one RUN cycle
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 32'h0, 1, 0, 0, SF, 1, 32'h200, 0, 32'h0, 0));   // 26-28 re-drain
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 1, SA, 0, 32'h0, 0, 32'h0, 1));       // 29 resume
    tbl.push_back(idle());                                                    // 30
    tbl.push_back(mk(0, 1, 32'h500, 1, 0, 0, S0, 1, 32'h500, 1, 32'h500, 0)); // 31 branch
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, SA, 0, 32'h0, 0, 32'h0, 0));       // 32 freeze mid-flush
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, S0, 1, 32'h500, 0, 32'h0, 0));     // 33 halt waits for RUN
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, S0, 0, 32'h0, 0, 32'h0, 0));       // 34 halt accepted
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 32'h0, 1, 0, 0, SF, 1, 32'h500, 0, 32'h0, 0));   // 35-37
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 1, SA, 0, 32'h0, 0, 32'h0, 1));       // 38 resume
    tbl.push_back(idle());                                                    // 39
    for (int i = 0; i < 3; i++) begin                                         // 40-45
      logic [31:0] t;
      t = 32'h600 + 32'h100 * i;
      tbl.push_back(mk(0, 1, t, 1, 0, 0, S0, 1, t, 1, t, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 0, 0, S0, 1, t, 0, 32'h0, 0));
    end
    tbl.push_back(mk(0, 1, 32'h900, 1, 1, 0, S0, 1, 32'h900, 1, 32'h900, 0)); // 46 branch beats halt
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, S0, 1, 32'h900, 0, 32'h0, 0));     // 47
    tbl.push_back(idle());                                                    // 48 halt was not latched

    drive(idle());
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef RV32_PIPE_PERF_CNT_EN
    check32("perf_stall_total", perf_stall_cnt, 32'd6);
    check32("perf_flush_total", perf_flush_cnt, 32'd6);
`else
    check32("perf_stall_off", perf_stall_cnt, 32'd0);
    check32("perf_flush_off", perf_flush_cnt, 32'd0);
`endif

    // Reset while draining with a pending redirect must drop the whole sequence.
    apply(mk(0, 0, 32'h0, 1, 1, 0, S0, 0, 32'h0, 0, 32'h0, 0), "rst_seq_halt");
    apply(mk(0, 1, 32'hA00, 1, 1, 0, SF, 1, 32'h900, 0, 32'h0, 0), "rst_seq_drain_br");
    drive(idle());
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check32("perf_stall_after_rst", perf_stall_cnt, 32'd0);
    check32("perf_flush_after_rst", perf_flush_cnt, 32'd0);
    apply(idle(), "after_rst_idle");
    apply(mk(0, 0, 32'h0, 1, 1, 0, S0, 0, 32'h0, 0, 32'h0, 0), "after_rst_halt");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 32'h0, 1, 0, 0, SF, 1, 32'h0, 0, 32'h0, 0), $sformatf("after_rst_drain%0d", i));
    apply(mk(0, 0, 32'h0, 1, 0, 1, SA, 0, 32'h0, 0, 32'h0, 1), "after_rst_halted");
    apply(idle(), "after_rst_no_redirect");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
